// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// LSU_MISALIGN_EN enables word-crossing accesses and their extra FSM states.
package lsu_pkg;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, LD0 = 3'd1, LD1 = 3'd2, RD0 = 3'd3,
    WR0  = 3'd4, RD1 = 3'd5, WR1 = 3'd6, RESP = 3'd7
  } lsu_state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, LD0 = 3'd1, RD0 = 3'd3, WR0 = 3'd4, RESP = 3'd7
  } lsu_state_t;
`endif

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size lives in funct3[1:0] for all legal codes.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] WORD_BYTES = 3'd4;

  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      SZ_B:    access_bytes = 3'd1;
      SZ_H:    access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      SZ_B:    size_mask = 4'b0001;
      SZ_H:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] offset, input logic [2:0] f3);
    crosses = ({1'b0, offset} + access_bytes(f3)) > WORD_BYTES;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend over a two-word window,
// and store merge of the target bytes into one memory word.
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] rd_dword,
  output logic [31:0] ld_data,
  input  logic [31:0] old_word,
  input  logic        hi_word,
  input  logic [31:0] st_data,
  output logic [31:0] wr_word
);

  logic [5:0]  sh;
  logic [31:0] ld_word;
  logic [63:0] st_shift;
  logic [7:0]  st_mask;
  logic [31:0] st_lane;
  logic [3:0]  lane_en;

  assign sh = {1'b0, offset, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ld_word = 32'(rd_dword >> sh);
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      F3_H:    ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'h0, ld_word[7:0]};
      F3_HU:   ld_data = {16'h0, ld_word[15:0]};
      default: ld_data = '0;
    endcase
  end

  // Bytes that spill past the first word land in the upper half of the window.
  always_comb begin
    st_shift = {32'h0, st_data} << sh;
    st_mask  = {4'h0, size_mask(funct3)} << offset;
    st_lane  = hi_word ? st_shift[63:32] : st_shift[31:0];
    lane_en  = hi_word ? st_mask[7:4] : st_mask[3:0];
    wr_word  = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) wr_word[i*8 +: 8] = st_lane[i*8 +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a single-port word memory.
// Define LSU_MISALIGN_EN to execute misaligned h/w accesses instead of rejecting them.
module load_store_unit import lsu_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rd_data
);

  lsu_state_t  state, state_nxt;
  logic [31:0] addr_q, wdata_q, buf_lo, buf_hi;
  logic [2:0]  funct3_q;
  logic        load_q, err_q;
  logic        accept, req_err, hi_sel;
  logic [31:0] word0_addr, ld_data, wr_word;

  assign accept     = req_valid && req_ready;
  assign word0_addr = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_EN
  logic cross;
  assign cross  = crosses(addr_q[1:0], funct3_q);
  assign hi_sel = (state == WR1);
`else
  assign hi_sel = 1'b0;
`endif

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: req_err = 1'b0;
      F3_BU, F3_HU:     req_err = !req_load;  // unsigned codes are load-only
      default:          req_err = 1'b1;
    endcase
`ifndef LSU_MISALIGN_EN
    if (req_funct3[1:0] == SZ_H && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == SZ_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)       state_nxt = RESP;
          else if (req_load) state_nxt = LD0;
          else if (req_funct3 == F3_W && req_addr[1:0] == 2'b00) state_nxt = WR0;
          else               state_nxt = RD0;
        end
      end
`ifdef LSU_MISALIGN_EN
      LD0:  state_nxt = cross ? LD1 : RESP;
      LD1:  state_nxt = RESP;
      RD0:  state_nxt = WR0;
      WR0:  state_nxt = cross ? RD1 : RESP;
      RD1:  state_nxt = WR1;
      WR1:  state_nxt = RESP;
`else
      LD0:  state_nxt = RESP;
      RD0:  state_nxt = WR0;
      WR0:  state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      LD0, RD0: begin
        mem_read = 1'b1;
        mem_addr = word0_addr;
      end
      WR0: begin
        mem_write   = 1'b1;
        mem_addr    = word0_addr;
        mem_wr_data = wr_word;
      end
`ifdef LSU_MISALIGN_EN
      LD1, RD1: begin
        mem_read = 1'b1;
        mem_addr = word0_addr + 32'd4;
      end
      WR1: begin
        mem_write   = 1'b1;
        mem_addr    = word0_addr + 32'd4;
        mem_wr_data = wr_word;
      end
`endif
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP && load_q && !err_q) ? ld_data : 32'h0;

  lsu_align u_align (
    .offset   (addr_q[1:0]),
    .funct3   (funct3_q),
    .rd_dword ({buf_hi, buf_lo}),
    .ld_data  (ld_data),
    .old_word (hi_sel ? buf_hi : buf_lo),
    .hi_word  (hi_sel),
    .st_data  (wdata_q),
    .wr_word  (wr_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      buf_lo   <= '0;
      buf_hi   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        load_q   <= req_load;
        err_q    <= req_err;
        buf_lo   <= '0;
        buf_hi   <= '0;
      end
      if (state == LD0 || state == RD0) buf_lo <= mem_rd_data;
`ifdef LSU_MISALIGN_EN
      if (state == LD1 || state == RD1) buf_hi <= mem_rd_data;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected responses,
// a negedge monitor pops and compares them and watches the memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_read, mem_write;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_load    (req_load),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Word memory indexed by addr[9:2]; all addresses used below map to distinct words.
  logic [31:0] mem [0:255];
  assign mem_rd_data = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] = mem_wr_data;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reads;
    int          writes;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] addr_log[$];
  int          rd_cnt = 0, wr_cnt = 0;
  int          checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: interface invariants every cycle, scoreboard pop on each response.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
      check("mem_addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      if (!mem_read && !mem_write) check("mem_idle_zero", mem_addr | mem_wr_data, 32'h0);
      if (!resp_valid) check("resp_idle_zero", resp_rdata | {31'h0, resp_err}, 32'h0);
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read || mem_write) addr_log.push_back(mem_addr);
      if (resp_valid) begin
        check("resp_expected", {31'h0, sbq.size() > 0}, 32'h1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
          check({e.name, "_latency"}, 32'(cycle - e.acc), 32'(e.lat));
          check({e.name, "_reads"}, 32'(rd_cnt), 32'(e.reads));
          check({e.name, "_writes"}, 32'(wr_cnt), 32'(e.writes));
        end
      end
    end
  end

  task automatic drive_req(input logic ld, input logic [2:0] f3, input logic [31:0] a, wd);
    req_valid  = 1'b1;
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic issue(input string name, input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, wd, exp_rdata, input logic exp_err,
                       input int lat, rd, wr);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    drive_req(ld, f3, a, wd);
    @(posedge clk); #1;
    rd_cnt = 0;
    wr_cnt = 0;
    addr_log.delete();
    // acc is the cycle in which the request was presented
    sbq.push_back('{name: name, rdata: exp_rdata, err: exp_err, lat: lat,
                    reads: rd, writes: wr, acc: cycle - 1});
    // Junk request while busy must be ignored, not queued.
    drive_req(1'($urandom), 3'b011, $urandom, $urandom);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 30) begin @(negedge clk); n++; end
    check({name, "_done"}, 32'(sbq.size()), 32'h0);
    sbq.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    check({name, "_resp"}, {31'h0, resp_valid} | {31'h0, resp_err} | resp_rdata, 32'h0);
    check({name, "_mem_ctl"}, {30'h0, mem_read, mem_write}, 32'h0);
    check({name, "_mem_bus"}, mem_addr | mem_wr_data, 32'h0);
  endtask

  // Start a store, reset it while the expected write is on the bus.
  task automatic abort_store(input logic [2:0] f3, input logic [31:0] a, wd,
                             input int edges, input logic [31:0] exp_wr_addr);
    @(negedge clk);
    drive_req(1'b0, f3, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (edges) @(posedge clk);
    #1;
    check("abort_in_write", {31'h0, mem_write}, 32'h1);
    check("abort_wr_addr", mem_addr, exp_wr_addr);
    #1 rst = 1'b1;
    #1 check_reset_outputs("abort_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Aligned loads from 0x100
    mem[8'h40] = 32'h8899AABB;
    issue("lb_101",  1'b1, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    issue("lbu_103", 1'b1, 3'b100, 32'h103, 32'h0, 32'h00000088, 1'b0, 2, 1, 0);
    issue("lh_102",  1'b1, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
    issue("lhu_100", 1'b1, 3'b101, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0);
    issue("lw_100",  1'b1, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);

    // Sub-word and full-word stores
    mem[8'h40] = 32'h11223344;
    issue("sb_102", 1'b0, 3'b000, 32'h102, 32'hFFFFFF5A, 32'h0, 1'b0, 3, 1, 1);
    check("sb_102_mem", mem[8'h40], 32'h115A3344);
    check("sb_102_waddr", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD, 32'h100);
    issue("sh_100", 1'b0, 3'b001, 32'h100, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1);
    check("sh_100_mem", mem[8'h40], 32'h115ABEEF);
    issue("sw_100", 1'b0, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1);
    check("sw_100_mem", mem[8'h40], 32'hCAFEF00D);
    issue("lw_100b", 1'b1, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0);

    // Illegal codes
    issue("ld_f3_011", 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue("ld_f3_111", 1'b1, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue("st_f3_100", 1'b0, 3'b100, 32'h100, 32'h5, 32'h0, 1'b1, 1, 0, 0);
    issue("st_f3_101", 1'b0, 3'b101, 32'h100, 32'h5, 32'h0, 1'b1, 1, 0, 0);
    check("err_no_store", mem[8'h40], 32'hCAFEF00D);

    // Misaligned accesses around 0x200
    mem[8'h80] = 32'h44332211;
    mem[8'h81] = 32'h88776655;
    issue("lh_202", 1'b1, 3'b001, 32'h202, 32'h0, 32'h00004433, 1'b0, 2, 1, 0);
`ifdef LSU_MISALIGN_EN
    issue("lw_203",  1'b1, 3'b010, 32'h203, 32'h0, 32'h77665544, 1'b0, 3, 2, 0);
    issue("lh_201",  1'b1, 3'b001, 32'h201, 32'h0, 32'h00003322, 1'b0, 2, 1, 0);
    issue("lhu_203", 1'b1, 3'b101, 32'h203, 32'h0, 32'h00005544, 1'b0, 3, 2, 0);
    issue("sh_203",  1'b0, 3'b001, 32'h203, 32'h0000ABCD, 32'h0, 1'b0, 5, 2, 2);
    check("sh_203_mem0", mem[8'h80], 32'hCD332211);
    check("sh_203_mem1", mem[8'h81], 32'h887766AB);
`else
    issue("lw_203",  1'b1, 3'b010, 32'h203, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue("lh_201",  1'b1, 3'b001, 32'h201, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue("sh_203",  1'b0, 3'b001, 32'h203, 32'h0000ABCD, 32'h0, 1'b1, 1, 0, 0);
    check("sh_203_mem0", mem[8'h80], 32'h44332211);
`endif

    // Address wrap at the top of memory
    mem[8'hFF] = 32'hA3A2A1A0;
    mem[8'h00] = 32'hB3B2B1B0;
`ifdef LSU_MISALIGN_EN
    issue("lw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h0, 32'hB1B0A3A2, 1'b0, 3, 2, 0);
    check("wrap_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD, 32'hFFFFFFFC);
    check("wrap_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD, 32'h00000000);
`else
    issue("lw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`endif

    // Reset in the middle of a store
    mem[8'h3F] = 32'h11111111;
    mem[8'h40] = 32'h22222222;
`ifdef LSU_MISALIGN_EN
    abort_store(3'b010, 32'h0FF, 32'hD4C3B2A1, 3, 32'h100);
    check("abort_mem_fc", mem[8'h3F], 32'hA1111111);
    check("abort_mem_100", mem[8'h40], 32'h22222222);
    issue("lw_0fc_after", 1'b1, 3'b010, 32'h0FC, 32'h0, 32'hA1111111, 1'b0, 2, 1, 0);
`else
    abort_store(3'b000, 32'h0FD, 32'h00000077, 1, 32'h0FC);
    check("abort_mem_fc", mem[8'h3F], 32'h11111111);
    issue("lw_0fc_after", 1'b1, 3'b010, 32'h0FC, 32'h0, 32'h11111111, 1'b0, 2, 1, 0);
`endif
    issue("lb_103_after", 1'b1, 3'b000, 32'h103, 32'h0, 32'h00000022, 1'b0, 2, 1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-003 SHALL have ports: req_load  in  1  1=load, 0=store; req_funct3  in  3  RV32I width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-004 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified.
REQ-005 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  extended load data; resp_err  out  1  request rejected.
REQ-006 SHALL have ports: mem_addr  out  32  word-aligned byte address; mem_wr_data  out  32  write word; mem_read  out  1; mem_write  out  1; mem_rd_data  in  32  combinational read word, little-endian.

Function
REQ-007 SHALL use FSM states IDLE, LD0, LD1, RD0, WR0, RD1, WR1, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL latch addr, funct3, load flag and wdata on accept; transition out of IDLE on the same edge.
REQ-009 SHALL always drive mem_addr[1:0]=00; first word = {addr[31:2],00}, second word = first+4 modulo 2^32.
REQ-010 SHALL never assert mem_read and mem_write together; mem_addr, mem_wr_data = 0 when neither asserted.
REQ-011 Load: LD0 reads first word (mem_read=1, captured at edge); LD1 only if access crosses word boundary; then RESP.
REQ-012 Load result: bytes extracted at offset addr[1:0]; b/h sign-extended, bu/hu zero-extended, w unmodified.
REQ-013 Store w aligned: WR0 writes req_wdata directly (no read); then RESP.
REQ-014 Store b/h/misaligned w: RD0 read first word, WR0 write merged word (only target bytes replaced); if crossing, RD1/WR1 same for second word; then RESP.
REQ-015 Latency accept-to-resp_valid: aligned lw/lb/lh 2 cycles; aligned sw 2; sb/sh 3; crossing load 3; crossing store 5.
REQ-016 RESP SHALL last exactly one cycle, resp_rdata valid with it (0 for stores and errors), then IDLE.
REQ-017 resp_err=1 for funct3 011/110/111 or store with 100/101: no memory access, IDLE->RESP directly, resp_rdata=0.
REQ-018 resp_valid, resp_err, resp_rdata SHALL be 0 outside RESP.
REQ-019 Requests while req_ready=0 SHALL be ignored (not queued); req_* may change freely after accept.

Reset
REQ-020 rst SHALL immediately force state IDLE, req_ready=1, all other outputs 0, internal latches 0.
REQ-021 rst mid-store SHALL abort; a WR0 already committed before rst remains in memory (partial store permitted).

Configuration
REQ-022 Macro LSU_MISALIGN_EN defined: h at offset 1/3 and w at offsets 1-3 execute per REQ-011/014 (offset 1 h stays in one word).
REQ-023 LSU_MISALIGN_EN undefined: any h with addr[0]=1 or w with addr[1:0]!=00 SHALL error per REQ-017; states LD1, RD1, WR1 not generated.

Structure
REQ-024 Package lsu_pkg SHALL hold the state enum, funct3 width constants and offset/crossing helper constants.
REQ-025 Sub-module lsu_align SHALL be combinational: load byte-lane extract/extend and store byte-lane merge; FSM stays in load_store_unit.

Verification
REQ-026 Mem word 0x100=0x8899AABB, lb addr 0x101 -> resp_rdata 0xFFFFFFAA, resp_valid 2 cycles after accept.
REQ-027 sb 0x5A to 0x102 over word 0x11223344 -> RD0, WR0 writes 0x115A3344 at 0x100, resp at cycle 3.
REQ-028 With macro: words 0x200=0x44332211, 0x204=0x88776655, lw 0x203 -> two reads, resp_rdata 0x77665544 at cycle 3; without macro -> resp_err=1, no mem_read.
REQ-029 With macro: lw 0xFFFFFFFE -> mem_addr 0xFFFFFFFC then 0x00000000 (wrap); funct3 011 load -> resp_err=1, resp_rdata=0.
REQ-030 sw crossing 0x0FF with macro, rst asserted during WR1 -> all outputs 0 immediately, word 0x0FC already updated, 0x100 unchanged, next request accepted normally.
